// File: rtl/pipe_chain_pkg.sv
// Shared types and helpers for the pipeline stage chain and its debug controller.
package pipe_chain_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2
    } dbg_state_e;

    localparam int CYCLE_CNT_W = 32;

    // Low bit index of stage k within a flattened NUM_STAGES*width bus.
    function automatic int stage_slice(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register: data plus valid, with flush, hold and bubble control.
module pipe_stage_reg #(
    parameter int WIDTH = 129
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    input  logic             i_flush,
    input  logic             i_hold,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Flush outranks hold so a squashed entry cannot be kept alive by a stall.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_adv) begin
            if (i_flush || (!i_hold && i_bubble)) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (!i_hold) begin
                r_data  <= i_data;
                r_valid <= i_valid;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with run/halt/step debug control and stage snapshot.
// Optional advance-cycle counter enabled by defining PIPE_STAGE_CHAIN_CYCLE_CNT_EN.
//
// state  | meaning
// S_RUN  | pipeline advances every cycle
// S_HALT | all stages frozen, waiting for a step burst or return to run
// S_STEP | advancing for a loaded number of cycles, then back to halt/run
module pipe_stage_chain
    import pipe_chain_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int WIDTH      = 129,
    parameter int STEP_W     = 8,
    parameter int SEL_W      = $clog2(NUM_STAGES)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_STAGES*WIDTH-1:0] i_data,
    input  logic                        i_valid,
    input  logic [NUM_STAGES-1:0]       i_stall,
    input  logic [NUM_STAGES-1:0]       i_flush,
    output logic [NUM_STAGES*WIDTH-1:0] o_data,
    output logic [NUM_STAGES-1:0]       o_valid,
    input  logic                        i_dbg_mode,
    input  logic                        i_dbg_step,
    input  logic [STEP_W-1:0]           i_dbg_steps,
    input  logic [SEL_W-1:0]            i_dbg_sel,
    output logic [WIDTH-1:0]            o_dbg_word,
    output logic                        o_dbg_busy,
    output logic                        o_dbg_done,
    output logic                        o_halted,
    output logic [CYCLE_CNT_W-1:0]      o_cycle_cnt
);

    dbg_state_e              r_state;
    dbg_state_e              w_state_nxt;
    logic [STEP_W-1:0]       r_cnt;
    logic [STEP_W-1:0]       w_cnt_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_adv;

    logic [NUM_STAGES-1:0]       w_hold;
    logic [NUM_STAGES-1:0]       w_bubble;
    logic [NUM_STAGES-1:0]       w_valid_in;
    logic [NUM_STAGES-1:0]       w_valid;
    logic [NUM_STAGES*WIDTH-1:0] w_data;
    logic [WIDTH-1:0]            w_sel_word;
    logic [WIDTH-1:0]            r_dbg_word;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The RUN->HALT transition cycle does not advance, so halting never slips one entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_RUN: begin
                if (i_dbg_mode) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_adv = 1'b1;
                end
            end
            S_HALT: begin
                if (!i_dbg_mode) begin
                    w_state_nxt = S_RUN;
                end else if (i_dbg_step && (i_dbg_steps != '0)) begin
                    w_state_nxt = S_STEP;
                    w_cnt_nxt   = i_dbg_steps;
                end
            end
            S_STEP: begin
                w_adv     = 1'b1;
                w_cnt_nxt = r_cnt - STEP_W'(1);
                if (r_cnt == STEP_W'(1)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = i_dbg_mode ? S_HALT : S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_hold = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_hold[k] = |(i_stall >> k);
        end
    end

    assign w_bubble   = {w_hold[NUM_STAGES-2:0], 1'b0};
    assign w_valid_in = {w_valid[NUM_STAGES-2:0], i_valid};

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH(WIDTH)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_adv   (w_adv),
            .i_flush (i_flush[k]),
            .i_hold  (w_hold[k]),
            .i_bubble(w_bubble[k]),
            .i_data  (i_data[stage_slice(k, WIDTH) +: WIDTH]),
            .i_valid (w_valid_in[k]),
            .o_data  (w_data[stage_slice(k, WIDTH) +: WIDTH]),
            .o_valid (w_valid[k])
        );
    end

    // Out-of-range selectors fall through the loop and read as zero.
    always_comb begin
        w_sel_word = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (i_dbg_sel == SEL_W'(k)) begin
                w_sel_word = w_data[stage_slice(k, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dbg_word <= '0;
        end else begin
            r_dbg_word <= w_sel_word;
        end
    end

`ifdef PIPE_STAGE_CHAIN_CYCLE_CNT_EN
    logic [CYCLE_CNT_W-1:0] r_cycle_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cycle_cnt <= '0;
        end else if (w_adv) begin
            r_cycle_cnt <= r_cycle_cnt + CYCLE_CNT_W'(1);
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`else
    assign o_cycle_cnt = '0;
`endif

    assign o_data     = w_data;
    assign o_valid    = w_valid;
    assign o_dbg_word = r_dbg_word;
    assign o_dbg_busy = (r_state == S_STEP);
    assign o_dbg_done = r_done;
    assign o_halted   = (r_state == S_HALT);

endmodule
